seg_scan: RTL

Downstream display stage for the traffic-light countdown generator. Takes the 8-bit binary countdown value and converts it to two BCD digits with a sequential double-dabble converter. Drives a 2-digit, common-anode, time-multiplexed seven-segment display (active-low segments and digit enables). Supports leading-zero blanking, overflow indication and a global blank.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_bin2bcd.sv | 98 +++++++++
 rtl/seg_scan.sv | 77 +++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display path:
// converter states, special segment patterns and the digit glyph table.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_e;

    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, dp kept dark
    localparam logic [7:0] SEG_TAB [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_OFF;
        end
        return SEG_TAB[d];
    endfunction

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Value/control inputs and display/status outputs of seg_scan.
// master drives num/blank; slave is the display block.
interface seg_scan_if;

    logic [7:0] num;
    logic       blank;
    logic       busy;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       ovf;
    logic [7:0] seg_n;
    logic [1:0] dig_n;

    modport master (
        output num, blank,
        input  busy, bcd_tens, bcd_ones, ovf, seg_n, dig_n
    );

    modport slave (
        input  num, blank,
        output busy, bcd_tens, bcd_ones, ovf, seg_n, dig_n
    );

endinterface

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble: captures a changed 8-bit value, shifts it
// through a 12-bit BCD scratch over 8 cycles, then commits the digits.
module seg_bin2bcd
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num,
    output logic       busy,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       ovf
);

    conv_state_e state_q, state_d;
    logic [7:0]  last_num_q, last_num_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] scr_q, scr_d;
    logic [11:0] scr_adj;
    logic [2:0]  iter_q, iter_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        last_num_d = last_num_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        iter_d     = iter_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        scr_adj    = {dd_adj(scr_q[11:8]),
                      dd_adj(scr_q[7:4]),
                      dd_adj(scr_q[3:0])};
        unique case (state_q)
            IDLE: begin
                if (num != last_num_q) begin
                    last_num_d = num;
                    bin_d      = num;
                    scr_d      = '0;
                    iter_d     = '0;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                if (iter_q == 3'd7) begin
                    state_d = COMMIT;
                end else begin
                    iter_d = iter_q + 3'd1;
                end
            end
            COMMIT: begin
                ones_d  = scr_q[3:0];
                tens_d  = scr_q[7:4];
                ovf_d   = (scr_q[11:8] != 4'd0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_num_q <= '0;
            bin_q      <= '0;
            scr_q      <= '0;
            iter_q     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_num_q <= last_num_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            iter_q     <= iter_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;
    assign tens = tens_q;
    assign ones = ones_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan.sv
// Two-digit multiplexed common-anode display driver with
// leading-zero blanking, overflow dash and global blank.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50,
    parameter bit LZB      = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);

    localparam int CW = $clog2(SCAN_DIV);

    logic          busy;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic          ovf;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic          sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;

    seg_bin2bcd u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .num  (bus.num),
        .busy (busy),
        .tens (tens),
        .ones (ones),
        .ovf  (ovf)
    );

    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        sel_d      = sel_q;
        if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            sel_d      = ~sel_q;
        end
        dig_d = sel_q ? 2'b01 : 2'b10;
        seg_d = seg_code(sel_q ? tens : ones);
        // blank beats overflow, overflow beats leading-zero blanking
        if (bus.blank) begin
            dig_d = 2'b11;
            seg_d = SEG_OFF;
        end else if (ovf) begin
            seg_d = SEG_DASH;
        end else if (LZB && sel_q && (tens == 4'd0)) begin
            dig_d = 2'b11;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            sel_q      <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= 2'b11;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.bcd_tens = tens;
    assign bus.bcd_ones = ones;
    assign bus.ovf      = ovf;
    assign bus.seg_n    = seg_q;
    assign bus.dig_n    = dig_q;

endmodule
